ddr3_req_frontend: RTL and testbench

//  Parametrised request front-end between the user request interface and the DDR3 command FSM.

---
 rtl/ddr3_req_frontend.sv | 171 +++++++++++++++++
 tb/tb_ddr3_req_frontend.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_req_frontend.sv
// Request front-end for the DDR3 command FSM: request FIFO, per-bank open-row
// table, head-of-queue row-hit classification and outstanding-read throttling.
module ddr3_req_frontend #(
   parameter int BANK_BITS  = 3,
   parameter int ROW_BITS   = 14,
   parameter int COL_BITS   = 10,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int MAX_RD     = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         user_req_valid,
   output logic                         user_req_ready,
   input  logic                         user_req_rnw,
   input  logic [BANK_BITS-1:0]         user_req_bank,
   input  logic [ROW_BITS-1:0]          user_req_row,
   input  logic [COL_BITS-1:0]          user_req_col,
   input  logic [DATA_WIDTH-1:0]        user_req_wdata,
   output logic                         cmd_valid,
   input  logic                         cmd_ready,
   output logic                         cmd_rnw,
   output logic [BANK_BITS-1:0]         cmd_bank,
   output logic [ROW_BITS-1:0]          cmd_row,
   output logic [COL_BITS-1:0]          cmd_col,
   output logic [DATA_WIDTH-1:0]        cmd_wdata,
   output logic [1:0]                   cmd_kind,
   input  logic                         precharge_all,
   input  logic                         rd_done,
   output logic [$clog2(DEPTH+1)-1:0]   req_count,
   output logic [$clog2(MAX_RD+1)-1:0]  rd_outstanding,
   output logic                         rd_underflow
);

   localparam int NUM_BANKS = 2 ** BANK_BITS;
   localparam int PTR_W     = $clog2(DEPTH);
   localparam int CNT_W     = $clog2(DEPTH + 1);
   localparam int RD_W      = $clog2(MAX_RD + 1);
   localparam int ENT_W     = 1 + BANK_BITS + ROW_BITS + COL_BITS + DATA_WIDTH;

   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [RD_W-1:0]  MAX_RD_C = RD_W'(MAX_RD);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [RD_W-1:0]  RD_ONE   = RD_W'(1);

   logic [ENT_W-1:0]    mem_q [DEPTH];
   logic [ENT_W-1:0]    mem_d [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [NUM_BANKS-1:0] open_q, open_d;
   logic [ROW_BITS-1:0] row_q [NUM_BANKS];
   logic [ROW_BITS-1:0] row_d [NUM_BANKS];
   logic [RD_W-1:0]     rd_out_q, rd_out_d;
   logic                underflow_q, underflow_d;

   logic [ENT_W-1:0]    head_s;
   logic                empty_s;
   logic                rd_block_s;
   logic                push_s;
   logic                pop_s;
   logic                rd_pop_s;

   // Head decode, handshakes and row-hit classification of the head entry
   always_comb begin
      head_s = mem_q[rd_ptr_q];
      {cmd_rnw, cmd_bank, cmd_row, cmd_col, cmd_wdata} = head_s;
      empty_s        = (count_q == {CNT_W{1'b0}});
      rd_block_s     = cmd_rnw && (rd_out_q == MAX_RD_C);
      cmd_valid      = !empty_s && !precharge_all && !rd_block_s;
      user_req_ready = (count_q != DEPTH_C);
      push_s         = user_req_valid && user_req_ready;
      pop_s          = cmd_valid && cmd_ready;
      if (!open_q[cmd_bank]) begin
         cmd_kind = 2'b01;
      end else if (row_q[cmd_bank] == cmd_row) begin
         cmd_kind = 2'b00;
      end else begin
         cmd_kind = 2'b10;
      end
   end

   // Next-state for FIFO, open-row table and read-tracking counters
   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      open_d      = open_q;
      row_d       = row_q;
      rd_out_d    = rd_out_q;
      underflow_d = underflow_q;
      rd_pop_s    = pop_s && cmd_rnw;

      if (push_s) begin
         mem_d[wr_ptr_q] = {user_req_rnw, user_req_bank, user_req_row, user_req_col, user_req_wdata};
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // precharge_all masks cmd_valid, so it never coincides with a pop
      if (precharge_all) begin
         open_d = {NUM_BANKS{1'b0}};
      end else if (pop_s) begin
         open_d[cmd_bank] = 1'b1;
         row_d[cmd_bank]  = cmd_row;
      end else begin
         open_d = open_q;
      end

      case ({rd_pop_s, rd_done})
         2'b10:   rd_out_d = rd_out_q + RD_ONE;
         2'b01: begin
            if (rd_out_q != {RD_W{1'b0}}) begin
               rd_out_d = rd_out_q - RD_ONE;
            end else begin
               rd_out_d = rd_out_q;
            end
         end
         default: rd_out_d = rd_out_q;
      endcase

      underflow_d = underflow_q || (rd_done && (rd_out_q == {RD_W{1'b0}}));
   end

   // State registers; reset discards every queued entry and closes all rows
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {ENT_W{1'b0}};
         end
         for (int b = 0; b < NUM_BANKS; b++) begin
            row_q[b] <= {ROW_BITS{1'b0}};
         end
         wr_ptr_q    <= {PTR_W{1'b0}};
         rd_ptr_q    <= {PTR_W{1'b0}};
         count_q     <= {CNT_W{1'b0}};
         open_q      <= {NUM_BANKS{1'b0}};
         rd_out_q    <= {RD_W{1'b0}};
         underflow_q <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         row_q       <= row_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         open_q      <= open_d;
         rd_out_q    <= rd_out_d;
         underflow_q <= underflow_d;
      end
   end

   assign req_count      = count_q;
   assign rd_outstanding = rd_out_q;
   assign rd_underflow   = underflow_q;

endmodule

// File: tb/tb_ddr3_req_frontend.sv
// Scoreboard bench for ddr3_req_frontend: expected entries are queued at push
// time and checked in order by a monitor whenever the DUT hands off a command.
module tb_ddr3_req_frontend;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        user_req_valid, user_req_ready, user_req_rnw;
   logic [2:0]  user_req_bank;
   logic [13:0] user_req_row;
   logic [9:0]  user_req_col;
   logic [15:0] user_req_wdata;
   logic        cmd_valid, cmd_ready, cmd_rnw;
   logic [2:0]  cmd_bank;
   logic [13:0] cmd_row;
   logic [9:0]  cmd_col;
   logic [15:0] cmd_wdata;
   logic [1:0]  cmd_kind;
   logic        precharge_all, rd_done;
   logic [3:0]  req_count;
   logic [2:0]  rd_outstanding;
   logic        rd_underflow;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        rnw;
      logic [2:0]  bank;
      logic [13:0] row;
      logic [9:0]  col;
      logic [15:0] wdata;
      logic [1:0]  kind;   // 2'b11: kind not checked
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;

   ddr3_req_frontend dut (
      .clk(clk), .rst(rst),
      .user_req_valid(user_req_valid), .user_req_ready(user_req_ready),
      .user_req_rnw(user_req_rnw), .user_req_bank(user_req_bank),
      .user_req_row(user_req_row), .user_req_col(user_req_col),
      .user_req_wdata(user_req_wdata),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
      .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
      .cmd_wdata(cmd_wdata), .cmd_kind(cmd_kind),
      .precharge_all(precharge_all), .rd_done(rd_done),
      .req_count(req_count), .rd_outstanding(rd_outstanding),
      .rd_underflow(rd_underflow)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: every accepted command must match the oldest expected entry
   always @(negedge clk) begin
      if (!rst && cmd_valid && cmd_ready) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_underrun: pop of bank %0d row %0d with nothing expected", cmd_bank, cmd_row);
         end else begin
            mon_e = sbq.pop_front();
            if ({cmd_rnw, cmd_bank, cmd_row, cmd_col, cmd_wdata} !==
                {mon_e.rnw, mon_e.bank, mon_e.row, mon_e.col, mon_e.wdata}) begin
               errors++;
               $display("FAIL sb_entry: got rnw=%0b b=%0d r=%0d c=%0d d=%h, want rnw=%0b b=%0d r=%0d c=%0d d=%h",
                        cmd_rnw, cmd_bank, cmd_row, cmd_col, cmd_wdata,
                        mon_e.rnw, mon_e.bank, mon_e.row, mon_e.col, mon_e.wdata);
            end
            if (mon_e.kind != 2'b11) begin
               checks++;
               if (cmd_kind !== mon_e.kind) begin
                  errors++;
                  $display("FAIL sb_kind: b=%0d r=%0d got %b want %b", cmd_bank, cmd_row, cmd_kind, mon_e.kind);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_req(input logic rnw, input logic [2:0] bank, input logic [13:0] row,
                           input logic [9:0] col, input logic [15:0] wdata, input logic [1:0] kind);
      user_req_valid = 1'b1;
      user_req_rnw   = rnw;
      user_req_bank  = bank;
      user_req_row   = row;
      user_req_col   = col;
      user_req_wdata = wdata;
      sbq.push_back('{rnw: rnw, bank: bank, row: row, col: col, wdata: wdata, kind: kind});
   endtask

   task automatic test_reset();
      user_req_valid = 1'b0; user_req_rnw = 1'b0; user_req_bank = 3'd0;
      user_req_row = 14'd0; user_req_col = 10'd0; user_req_wdata = 16'd0;
      cmd_ready = 1'b0; precharge_all = 1'b0; rd_done = 1'b0;
      #3 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if ({req_count, rd_outstanding, rd_underflow, cmd_valid, user_req_ready} !== {4'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state: cnt=%0d out=%0d uf=%0b vld=%0b rdy=%0b, want 0 0 0 0 1",
                  req_count, rd_outstanding, rd_underflow, cmd_valid, user_req_ready);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      cmd_ready = 1'b1;
      push_req(1'b0, 3'd0, 14'd5, 10'd3, 16'hBEEF, 2'b01);
      tick();
      user_req_valid = 1'b0;
      checks++;
      if ({req_count, cmd_valid, cmd_kind, cmd_wdata} !== {4'd1, 1'b1, 2'b01, 16'hBEEF}) begin
         errors++;
         $display("FAIL first_push: cnt=%0d vld=%0b kind=%b d=%h, want 1 1 01 beef", req_count, cmd_valid, cmd_kind, cmd_wdata);
      end
      tick();
      checks++;
      if ({req_count, cmd_valid} !== {4'd0, 1'b0}) begin
         errors++;
         $display("FAIL first_pop: cnt=%0d vld=%0b, want 0 0", req_count, cmd_valid);
      end
      push_req(1'b1, 3'd0, 14'd5, 10'd4, 16'd0, 2'b00);
      tick();
      user_req_valid = 1'b0;
      checks++;
      if (cmd_kind !== 2'b00) begin
         errors++;
         $display("FAIL row_hit: kind=%b want 00", cmd_kind);
      end
      tick();
      push_req(1'b1, 3'd0, 14'd9, 10'd5, 16'd0, 2'b10);
      tick();
      user_req_valid = 1'b0;
      checks++;
      if (cmd_kind !== 2'b10) begin
         errors++;
         $display("FAIL row_conflict: kind=%b want 10", cmd_kind);
      end
      tick();
      push_req(1'b0, 3'd0, 14'd9, 10'd6, 16'h1234, 2'b00);
      tick();
      user_req_valid = 1'b0;
      tick();
      checks++;
      if (rd_outstanding !== 3'd2) begin
         errors++;
         $display("FAIL rd_out_two: got %0d want 2", rd_outstanding);
      end
      rd_done = 1'b1;
      tick();
      tick();
      rd_done = 1'b0;
      checks++;
      if (rd_outstanding !== 3'd0) begin
         errors++;
         $display("FAIL rd_out_drain: got %0d want 0", rd_outstanding);
      end
   endtask

   task automatic test_rd_throttle();
      cmd_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         push_req(1'b1, 3'd1, 14'd7, 10'(i), 16'd0, (i == 0) ? 2'b01 : 2'b00);
         tick();
      end
      user_req_valid = 1'b0;
      cmd_ready = 1'b1;
      repeat (6) tick();
      checks++;
      if ({req_count, rd_outstanding, cmd_valid} !== {4'd4, 3'd4, 1'b0}) begin
         errors++;
         $display("FAIL rd_throttle: cnt=%0d out=%0d vld=%0b, want 4 4 0", req_count, rd_outstanding, cmd_valid);
      end
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      checks++;
      if ({cmd_valid, rd_outstanding} !== {1'b1, 3'd3}) begin
         errors++;
         $display("FAIL rd_release: vld=%0b out=%0d, want 1 3", cmd_valid, rd_outstanding);
      end
      tick();
      checks++;
      if ({req_count, rd_outstanding} !== {4'd3, 3'd4}) begin
         errors++;
         $display("FAIL rd_fifth_pop: cnt=%0d out=%0d, want 3 4", req_count, rd_outstanding);
      end
      rd_done = 1'b1;
      repeat (7) tick();
      rd_done = 1'b0;
      checks++;
      if ({req_count, rd_outstanding, rd_underflow} !== {4'd0, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL rd_drain: cnt=%0d out=%0d uf=%0b, want 0 0 0", req_count, rd_outstanding, rd_underflow);
      end
   endtask

   task automatic test_fill_wrap();
      cmd_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         push_req(1'b0, 3'd2, 14'd11, 10'(i), 16'(16'hA000 + i), (i == 0) ? 2'b01 : 2'b00);
         tick();
      end
      user_req_valid = 1'b1;
      user_req_wdata = 16'hDEAD;
      #1;
      checks++;
      if ({req_count, user_req_ready} !== {4'd8, 1'b0}) begin
         errors++;
         $display("FAIL full: cnt=%0d rdy=%0b, want 8 0", req_count, user_req_ready);
      end
      tick();
      cmd_ready = 1'b1;
      #1;
      checks++;
      if ({req_count, user_req_ready} !== {4'd8, 1'b0}) begin
         errors++;
         $display("FAIL full_no_bypass: cnt=%0d rdy=%0b, want 8 0", req_count, user_req_ready);
      end
      tick();
      user_req_valid = 1'b0;
      checks++;
      if (req_count !== 4'd7) begin
         errors++;
         $display("FAIL full_pop: cnt=%0d want 7", req_count);
      end
      repeat (3) tick();
      for (int i = 0; i < 20; i++) begin
         push_req(1'b0, 3'd2, 14'd11, 10'(100 + i), 16'(i * 37 + 5), 2'b00);
         tick();
      end
      user_req_valid = 1'b0;
      checks++;
      if (req_count !== 4'd4) begin
         errors++;
         $display("FAIL push_pop_count: cnt=%0d want 4", req_count);
      end
      repeat (4) tick();
      checks++;
      if ({req_count, sbq.size() == 0} !== {4'd0, 1'b1}) begin
         errors++;
         $display("FAIL wrap_drain: cnt=%0d pending=%0d, want 0 0", req_count, sbq.size());
      end
   endtask

   task automatic test_precharge();
      cmd_ready = 1'b0;
      for (int b = 0; b < 8; b++) begin
         push_req(1'b0, 3'(b), 14'(100 + b), 10'd0, 16'(b), (b < 3) ? 2'b10 : 2'b01);
         tick();
      end
      user_req_valid = 1'b0;
      cmd_ready = 1'b1;
      repeat (8) tick();
      cmd_ready = 1'b0;
      push_req(1'b1, 3'd3, 14'd103, 10'd7, 16'd0, 2'b01);
      tick();
      user_req_valid = 1'b0;
      checks++;
      if ({cmd_valid, cmd_kind} !== {1'b1, 2'b00}) begin
         errors++;
         $display("FAIL pre_prea_hit: vld=%0b kind=%b, want 1 00", cmd_valid, cmd_kind);
      end
      precharge_all = 1'b1;
      cmd_ready = 1'b1;
      #1;
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL prea_mask: vld=%0b want 0", cmd_valid);
      end
      tick();
      precharge_all = 1'b0;
      #1;
      checks++;
      if ({cmd_valid, cmd_kind} !== {1'b1, 2'b01}) begin
         errors++;
         $display("FAIL post_prea_idle: vld=%0b kind=%b, want 1 01", cmd_valid, cmd_kind);
      end
      tick();
      cmd_ready = 1'b0;
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
   endtask

   task automatic test_underflow_reset();
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      checks++;
      if ({rd_underflow, rd_outstanding} !== {1'b1, 3'd0}) begin
         errors++;
         $display("FAIL underflow_set: uf=%0b out=%0d, want 1 0", rd_underflow, rd_outstanding);
      end
      repeat (2) tick();
      checks++;
      if (rd_underflow !== 1'b1) begin
         errors++;
         $display("FAIL underflow_sticky: uf=%0b want 1", rd_underflow);
      end
      cmd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_req(1'b0, 3'd5, 14'd50, 10'(i), 16'(16'h5500 + i), (i == 0) ? 2'b01 : 2'b00);
         tick();
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({req_count, cmd_valid, rd_underflow, user_req_ready} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL async_reset: cnt=%0d vld=%0b uf=%0b rdy=%0b, want 0 0 0 1",
                  req_count, cmd_valid, rd_underflow, user_req_ready);
      end
      user_req_valid = 1'b0;
      sbq.delete();
      tick();
      rst = 1'b0;
      tick();
      push_req(1'b0, 3'd5, 14'd50, 10'd9, 16'h7777, 2'b01);
      tick();
      user_req_valid = 1'b0;
      checks++;
      if ({cmd_valid, cmd_kind} !== {1'b1, 2'b01}) begin
         errors++;
         $display("FAIL table_cleared: vld=%0b kind=%b, want 1 01", cmd_valid, cmd_kind);
      end
      tick();
      cmd_ready = 1'b0;
      checks++;
      if ({req_count, sbq.size() == 0} !== {4'd0, 1'b1}) begin
         errors++;
         $display("FAIL final_drain: cnt=%0d pending=%0d, want 0 0", req_count, sbq.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rd_throttle();
      test_fill_wrap();
      test_precharge();
      test_underflow_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
